adc_frame_scheduler: RTL and testbench
======================================

Name: adc_frame_scheduler

Overview:
- Sequences the MCP3002 ADC front end for the OFDM receiver.
- Generates the sampling tick, issues one conversion request per tick to the existing MCP3002 SPI reader, and writes each returned sample into a ping-pong frame buffer.
- Hands completed frames to the demodulation block through a valid/ack handshake.
- Sits between the MCP3002 reader and the demodulator buffer/FFT input.

Parameters:
- CLK_FREQ, 24_000_000, system clock frequency in Hz.
- ADC_SAMPLING_FREQ, 48_000, sample rate in Hz. PERIOD = CLK_FREQ/ADC_SAMPLING_FREQ (500 at the defaults); PERIOD must be at least 4.
- FRAME_LEN, 1024, samples per frame; must be a power of two.
- SAMPLE_W, 10, ADC sample width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  run sampling.
- adc_start  out  1  one-cycle conversion request to the MCP3002 reader.
- adc_done  in  1  one-cycle pulse; adc_data is valid in the same cycle.
- adc_data  in  SAMPLE_W  converted sample.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  log2(FRAME_LEN)+1  buffer address; MSB = bank, low bits = sample index.
- wr_data  out  SAMPLE_W  sample to write.
- frame_valid  out  1  a complete frame is pending for the demodulator.
- frame_bank  out  1  bank holding the pending frame.
- frame_ack  in  1  demodulator has released the pending frame.
- tick_miss  out  1  sticky: a tick arrived while a conversion was in flight.
- overrun_count  out  8  frames discarded because of a missing ack; saturates at 255.

Behaviour:
- Reset (async, immediate): every output 0, tick counter 0, sample index 0, write bank 0, FSM in IDLE. A conversion in flight at reset is abandoned; a later adc_done pulse is ignored because the FSM is not in WAIT.
- Tick counter:
  - Counts 0..PERIOD-1 while enable=1.
  - tick=1 in the cycle the counter equals PERIOD-1, then the counter wraps to 0.
  - enable=0 holds the counter at 0.
- FSM:
  - IDLE: on tick, go to START.
  - START: adc_start=1 for exactly this cycle, then go to WAIT.
  - WAIT: hold until adc_done=1; latch adc_data, go to WRITE.
  - WRITE: wr_en=1 for exactly this cycle, with wr_addr={bank, index} and wr_data=latched sample. Then go to IDLE.
- Latency: adc_start is asserted 1 cycle after tick. wr_en is asserted 1 cycle after adc_done.
- tick while FSM≠IDLE: the tick is dropped and tick_miss is set to 1. It stays set until rst.
- Index and bank update, in the WRITE cycle:
  - If index < FRAME_LEN-1: index+1.
  - Otherwise, frame completion: index returns to 0, then
    - frame_valid=0, or frame_ack in the same cycle: the next cycle has frame_valid=1 and frame_bank=current bank, and the write bank toggles.
    - frame_valid=1 and no ack: the just-filled frame is discarded. The bank does not toggle; the same bank is refilled. overrun_count increments, saturating at 255. frame_valid and frame_bank are unchanged.
- frame_ack:
  - With frame_valid=1: frame_valid clears the next cycle.
  - With frame_valid=0: ignored.
  - Simultaneous with completion: the ack is processed first, so no overrun occurs and frame_valid stays 1 with the new bank.
- Invariant: writes never target frame_bank while frame_valid=1.
- enable deasserted mid-conversion: the in-flight conversion completes and is written. No new ticks are generated. index and bank are retained, so the frame resumes when enable returns.
- adc_done outside WAIT is ignored.

Test Plan:
- Reset then enable=1, with an ADC model returning done 40 cycles after start with data=idx[9:0]:
  - first adc_start at cycle 500 after enable;
  - wr_en at cycle 541 with addr=0, data=0;
  - adc_start spacing is exactly 500 cycles.
- Fill 1024 samples with frame_ack never asserted:
  - frame_valid=1 and frame_bank=0 after sample 1023;
  - the next write has wr_addr=0x400.
- Continue without ack through the second frame:
  - at its completion overrun_count=1 and frame_bank stays 0;
  - writes restart at 0x400.
- Assert frame_ack in the exact WRITE cycle of the index-1023 write, with frame_valid=1:
  - no overrun increment;
  - frame_valid stays 1 and frame_bank toggles;
  - the next write goes to the other bank at index 0.
- ADC model with a 600-cycle done delay:
  - tick_miss=1 after the second tick;
  - samples are written every 1000 cycles, with no duplicate writes.
- Assert rst during WAIT at index 300:
  - all outputs 0 immediately;
  - a late adc_done is ignored;
  - after release, the first write goes to addr 0.

Source files
------------

// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler
//   Drives the MCP3002 front end of the OFDM receiver. A free-running
//   sample tick launches one conversion on the SPI reader, and each
//   returned sample is written into a ping-pong frame buffer. Completed
//   frames are offered to the demodulator through a valid/ack handshake.
//
// Ports
//   clk_i            system clock
//   rst_i            asynchronous, active-high reset
//   enable_i         run the sample tick
//   adc_start_o      one-cycle conversion request to the MCP3002 reader
//   adc_done_i       one-cycle conversion-complete pulse
//   adc_data_i       sample, valid together with adc_done_i
//   wr_en_o          frame buffer write strobe
//   wr_addr_o        {bank, sample index}
//   wr_data_o        sample being written
//   frame_valid_o    a complete frame is waiting for the demodulator
//   frame_bank_o     bank that holds the waiting frame
//   frame_ack_i      demodulator releases the waiting frame
//   tick_miss_o      sticky: a tick arrived while a conversion was busy
//   overrun_count_o  frames dropped for lack of an ack, saturating at 255
//
// Parameter rules: CLK_FREQ/ADC_SAMPLING_FREQ >= 4, FRAME_LEN a power of two.
//
// state  | meaning
// IDLE   | waiting for the next sample tick
// START  | conversion request pulse to the reader
// WAIT   | conversion in flight, waiting for adc_done_i
// WRITE  | buffer write of the captured sample, index/bank bookkeeping

module adc_frame_scheduler #(
  parameter int CLK_FREQ          = 24_000_000,
  parameter int ADC_SAMPLING_FREQ = 48_000,
  parameter int FRAME_LEN         = 1024,
  parameter int SAMPLE_W          = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  output logic                          adc_start_o,
  input  logic                          adc_done_i,
  input  logic [SAMPLE_W-1:0]           adc_data_i,
  output logic                          wr_en_o,
  output logic [$clog2(FRAME_LEN):0]    wr_addr_o,
  output logic [SAMPLE_W-1:0]           wr_data_o,
  output logic                          frame_valid_o,
  output logic                          frame_bank_o,
  input  logic                          frame_ack_i,
  output logic                          tick_miss_o,
  output logic [7:0]                    overrun_count_o
);

  localparam int PERIOD = CLK_FREQ / ADC_SAMPLING_FREQ;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                bank_q, bank_d;
  logic                fv_q, fv_d;
  logic                fb_q, fb_d;
  logic                miss_q, miss_d;
  logic [7:0]          ovr_q, ovr_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;

  logic tick;
  logic frame_done;

  assign tick       = enable_i && (cnt_q == CNT_W'(PERIOD - 1));
  assign frame_done = (state_q == S_WRITE) && (idx_q == IDX_W'(FRAME_LEN - 1));

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; ticks outside IDLE are simply not taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (adc_done_i) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs; address/data are forced to zero outside the write strobe
  always_comb begin
    adc_start_o     = (state_q == S_START);
    wr_en_o         = (state_q == S_WRITE);
    wr_addr_o       = '0;
    wr_data_o       = '0;
    if (state_q == S_WRITE) begin
      wr_addr_o = {bank_q, idx_q};
      wr_data_o = sample_q;
    end
    frame_valid_o   = fv_q;
    frame_bank_o    = fb_q;
    tick_miss_o     = miss_q;
    overrun_count_o = ovr_q;
  end

  // datapath next-state
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bank_d   = bank_q;
    fv_d     = fv_q;
    fb_d     = fb_q;
    miss_d   = miss_q;
    ovr_d    = ovr_q;
    sample_d = sample_q;

    if (!enable_i || tick) cnt_d = '0;
    else                   cnt_d = cnt_q + 1'b1;

    if (tick && (state_q != S_IDLE)) miss_d = 1'b1;

    if ((state_q == S_WAIT) && adc_done_i) sample_d = adc_data_i;

    if (state_q == S_WRITE) idx_d = frame_done ? '0 : idx_q + 1'b1;

    // An ack coinciding with completion frees the slot first, so the new
    // frame is handed over instead of being counted as an overrun.
    if (frame_done) begin
      if (!fv_q || frame_ack_i) begin
        fv_d   = 1'b1;
        fb_d   = bank_q;
        bank_d = ~bank_q;
      end else if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end else if (frame_ack_i) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      bank_q   <= 1'b0;
      fv_q     <= 1'b0;
      fb_q     <= 1'b0;
      miss_q   <= 1'b0;
      ovr_q    <= 8'd0;
      sample_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bank_q   <= bank_d;
      fv_q     <= fv_d;
      fb_q     <= fb_d;
      miss_q   <= miss_d;
      ovr_q    <= ovr_d;
      sample_q <= sample_d;
    end
  end

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Bench for adc_frame_scheduler, scaled down to PERIOD=20 and FRAME_LEN=16.
// The reference model works in terms of event times: when the next tick
// falls, when a request and a write are due, and what the frame
// bookkeeping must look like after each write.
module tb_adc_frame_scheduler;

  localparam int CLK_FREQ = 2000;
  localparam int FS       = 100;
  localparam int P        = CLK_FREQ / FS;
  localparam int FL       = 16;
  localparam int SW       = 10;
  localparam int AW       = $clog2(FL) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b0;
  logic          adc_done_i = 1'b0;
  logic [SW-1:0] adc_data_i = '0;
  logic          frame_ack_i = 1'b0;
  logic          adc_start_o, wr_en_o, frame_valid_o, frame_bank_o, tick_miss_o;
  logic [AW-1:0] wr_addr_o;
  logic [SW-1:0] wr_data_o;
  logic [7:0]    overrun_count_o;

  always #5 clk_i = ~clk_i;

  adc_frame_scheduler #(
    .CLK_FREQ(CLK_FREQ), .ADC_SAMPLING_FREQ(FS), .FRAME_LEN(FL), .SAMPLE_W(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .adc_start_o(adc_start_o), .adc_done_i(adc_done_i), .adc_data_i(adc_data_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .frame_valid_o(frame_valid_o), .frame_bank_o(frame_bank_o),
    .frame_ack_i(frame_ack_i), .tick_miss_o(tick_miss_o),
    .overrun_count_o(overrun_count_o)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // environment controls
  int  cyc = 0;
  int  fix_delay = 5;
  bit  rand_delay = 0;
  int  ack_mode = 0;       // 0 none, 1 ack in completion write, 2 random
  bit  rand_en = 0;
  bit  spurious = 0;
  int  en_off = 0;
  int  done_at = -1;

  // reference model
  int            phase;
  bit            busy, awaiting;
  int            start_at, write_at;
  logic [SW-1:0] m_data;
  int            m_idx, m_ovr;
  bit            m_bank, m_fv, m_fb, m_tm;

  // directed observations
  int  first_start = -1;
  int  first_write = -1;
  int  first_addr  = -1;
  bit  watch_first = 0;

  task automatic model_reset();
    phase = 0; busy = 0; awaiting = 0;
    start_at = -1; write_at = -1; m_data = '0;
    m_idx = 0; m_ovr = 0; m_bank = 0; m_fv = 0; m_fb = 0; m_tm = 0;
  endtask

  task automatic drive_inputs();
    if (rand_en && en_off == 0 && $urandom_range(0, 49) == 0) en_off = $urandom_range(1, 30);
    if (en_off > 0) begin
      enable_i = 1'b0;
      en_off--;
    end else begin
      enable_i = 1'b1;
    end
    adc_done_i = (cyc == done_at) ||
                 (spurious && !awaiting && $urandom_range(0, 39) == 0);
    adc_data_i = SW'($urandom);
    case (ack_mode)
      1:       frame_ack_i = (write_at == cyc) && (m_idx == FL - 1) && m_fv;
      2:       frame_ack_i = ($urandom_range(0, 24) == 0);
      default: frame_ack_i = 1'b0;
    endcase
  endtask

  task automatic check_and_model();
    bit tick;
    check_val("adc_start", adc_start_o, cyc == start_at);
    check_val("wr_en", wr_en_o, cyc == write_at);
    if (cyc == write_at) begin
      check_val("wr_addr", wr_addr_o, m_bank * FL + m_idx);
      check_val("wr_data", wr_data_o, m_data);
    end
    check_val("frame_valid", frame_valid_o, m_fv);
    check_val("frame_bank", frame_bank_o, m_fb);
    check_val("overrun", overrun_count_o, m_ovr);
    check_val("tick_miss", tick_miss_o, m_tm);

    if (adc_start_o) begin
      done_at = cyc + (rand_delay ? $urandom_range(1, P - 4) : fix_delay);
      if (first_start < 0) first_start = cyc;
    end
    if (wr_en_o && watch_first) begin
      watch_first = 0;
      first_write = cyc;
      first_addr  = wr_addr_o;
    end

    tick  = enable_i && (phase == P - 1);
    phase = !enable_i ? 0 : (tick ? 0 : phase + 1);
    if (tick) begin
      if (busy) m_tm = 1;
      else begin
        busy = 1;
        start_at = cyc + 1;
      end
    end
    if (adc_done_i && awaiting) begin
      awaiting = 0;
      write_at = cyc + 1;
      m_data   = adc_data_i;
    end
    if (cyc == start_at) awaiting = 1;
    if (cyc == write_at) begin
      busy = 0;
      if (m_idx == FL - 1) begin
        m_idx = 0;
        if (!m_fv || frame_ack_i) begin
          m_fv = 1; m_fb = m_bank; m_bank = !m_bank;
        end else if (m_ovr < 255) begin
          m_ovr++;
        end
      end else begin
        m_idx++;
        if (frame_ack_i && m_fv) m_fv = 0;
      end
    end else if (frame_ack_i && m_fv) begin
      m_fv = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      check_and_model();
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_start"}, adc_start_o, 0);
    check_val({tag, "_wr_en"}, wr_en_o, 0);
    check_val({tag, "_addr"}, wr_addr_o, 0);
    check_val({tag, "_data"}, wr_data_o, 0);
    check_val({tag, "_fv"}, frame_valid_o, 0);
    check_val({tag, "_fb"}, frame_bank_o, 0);
    check_val({tag, "_miss"}, tick_miss_o, 0);
    check_val({tag, "_ovr"}, overrun_count_o, 0);
  endtask

  initial begin
    bit found;
    int c0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;
    cyc = 0;
    watch_first = 1;

    // steady sampling, fixed latency, no ack: hand-off then overruns
    fix_delay = 5;
    run_cycles(1100);
    check_val("first_start", first_start, P);
    check_val("first_write", first_write, P + 5 + 1);
    check_val("first_addr", first_addr, 0);
    check_val("ovr_after_3_frames", overrun_count_o, 2);
    check_val("bank_held", frame_bank_o, 0);

    // ack exactly in the completing write: hand-over without overrun
    ack_mode = 1;
    run_cycles(700);
    check_val("ovr_no_increment", overrun_count_o, 2);

    // randomized latency, acks, enable gaps and stray done pulses
    ack_mode = 2; rand_delay = 1; rand_en = 1; spurious = 1;
    run_cycles(2500);

    // conversion longer than the sample period
    ack_mode = 0; rand_delay = 0; rand_en = 0; en_off = 0; spurious = 0;
    fix_delay = P + 4;
    run_cycles(400);
    check_val("tick_miss_long", tick_miss_o, 1);

    // reset in the middle of a conversion at index 5
    fix_delay = 10;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (awaiting && m_idx == 5 && cyc >= start_at + 2) found = 1;
      else run_cycles(1);
    end
    check_val("rst_point_found", found, 1);
    if (found) begin
      c0 = cyc;
      rst_i = 1'b1;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      cyc = c0 + 2;
      watch_first = 1;
      fix_delay = 5;
      run_cycles(200);
      check_val("post_rst_addr", first_addr, 0);
      check_val("post_rst_write_cycle", first_write, c0 + 2 + P + 5 + 1);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
